counter_ud: RTL and testbench
=============================

# counter_ud

Parametrised up/down counter for the control datapath; next generation of the team's single-direction clear/increment counter. It adds a programmable ceiling, decrement, parallel load, wrap or saturate behaviour, a runtime prescaler on count requests, and wrap/overflow reporting. It is used for event counting, timeouts and credit tracking, where the ceiling and division ratio are set by software.

## Interface
- WIDTH, 8, counter width in bits
- DIV_W, 4, prescaler width in bits
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear of counter, prescaler and flags
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value loaded when load=1
- inc  input  1  count-up request
- dec  input  1  count-down request
- div  input  DIV_W  prescale: one step per div+1 accepted requests
- max_val  input  WIDTH  counter ceiling; range is 0..max_val
- cnt  output  WIDTH  counter value, registered
- eq  output  1  combinational, cnt == max_val
- zero  output  1  combinational, cnt == 0
- wrap  output  1  registered one-cycle pulse on a wrap/saturation event
- ovf  output  1  sticky, set with any wrap pulse, cleared only by clr or reset

## Operation
- Priority per cycle: clr > load > count. One action per edge.
- clr: cnt=0, prescaler=0, wrap=0, ovf=0.
- load: cnt=load_val, prescaler=0, wrap=0, ovf unchanged. load_val is not range-checked.
- Request: req = inc XOR dec. inc=dec=1 is no request; prescaler and cnt hold.
- Prescaler pre (DIV_W bits): with req and pre >= div, a tick occurs and pre <= 0. With req and pre < div, pre <= pre+1. Without req, pre holds. div=0 means every request ticks. Lowering div below the current pre gives a tick on the next request.
- Tick up, cnt < max_val: cnt+1.
- Tick up, cnt >= max_val: SATURATE=0 gives cnt <= 0 and wrap=1. SATURATE=1 gives cnt <= max_val (clamps an out-of-range cnt) and wrap=1.
- Tick down, cnt > 0: cnt-1. This also applies when cnt > max_val.
- Tick down, cnt == 0: SATURATE=0 gives cnt <= max_val and wrap=1. SATURATE=1 gives cnt holds at 0 and wrap=1.
- max_val=0: every up or down tick is a limit event; cnt stays 0 and wrap pulses.
- wrap is 0 on every edge without a limit event. ovf <= ovf | wrap_next.
- Arithmetic is unsigned WIDTH-bit, with no intermediate overflow. Compare before increment, so cnt = 2^WIDTH-1 never rolls via carry.

## Timing
- Reset values: cnt=0, pre=0, wrap=0, ovf=0. eq = (max_val==0), zero=1.
- Latency is 1 cycle: the request sampled at edge N updates cnt and wrap visible after edge N.
- wrap is high exactly the cycle the wrapped or clamped cnt value is visible.
- eq and zero follow cnt and max_val combinationally, with no extra delay.
- An asynchronous rst_n assertion mid-count clears all state immediately. The first count after deassertion needs div+1 requests.
- clr or load in the same cycle as a tick discards the tick and generates no wrap.

## Test plan
- Reset, WIDTH=8, div=0, max_val=5, inc held 7 cycles -> cnt 1,2,3,4,5,0,1; wrap high only with cnt=0; ovf=1 from then on; eq high while cnt=5.
- div=2, inc held 9 cycles from cnt=0 -> cnt steps on request 3, 6, 9 to 1, 2, 3; pre sequence 1,2,0 repeating.
- SATURATE=1, max_val=3: inc 6 ticks -> cnt 1,2,3,3,3,3 with wrap on the 4th to 6th ticks. Then dec 5 ticks -> 2,1,0,0,0 with wrap on the last two.
- SATURATE=0, cnt=0, max_val=9, dec 1 tick -> cnt=9, wrap=1; inc=dec=1 for 3 cycles -> cnt=9, pre unchanged.
- load_val=200, max_val=100, load then inc -> cnt=200, then 0 with wrap (wrap mode) or 100 with wrap (saturate mode); dec from 200 -> 199.
- Mid-count: clr and inc together -> cnt=0, ovf=0, no wrap. rst_n pulsed low mid-cycle -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/counter_ud.sv
// Up/down counter with programmable ceiling, runtime prescaler on count requests,
// wrap-or-saturate limit handling and wrap/overflow reporting.
module counter_ud #(
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt,
  output logic             eq,
  output logic             zero,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] r_cnt;
  logic [DIV_W-1:0] r_pre;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_req;
  logic             w_tick;
  logic [WIDTH:0]   w_step;

  // Limit handling: returns {limit_event, next_count}. Comparing before the
  // +1/-1 keeps an all-ones count from rolling over through the carry.
  function automatic logic [WIDTH:0] f_step(input logic             up,
                                            input logic [WIDTH-1:0] c,
                                            input logic [WIDTH-1:0] m);
    logic [WIDTH:0] res;
    if (up) begin
      if (c < m)              res = {1'b0, c + WIDTH'(1)};
      else if (SATURATE != 0) res = {1'b1, m};
      else                    res = {1'b1, {WIDTH{1'b0}}};
    end else begin
      if (c != '0)            res = {1'b0, c - WIDTH'(1)};
      else if (SATURATE != 0) res = {1'b1, {WIDTH{1'b0}}};
      else                    res = {1'b1, m};
    end
    return res;
  endfunction

  assign w_req  = inc ^ dec;
  assign w_tick = w_req && (r_pre >= div);
  assign w_step = f_step(inc, r_cnt, max_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pre  <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_pre  <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (load) begin
      r_cnt  <= load_val;
      r_pre  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_tick) begin
        r_pre  <= '0;
        r_cnt  <= w_step[WIDTH-1:0];
        r_wrap <= w_step[WIDTH];
        r_ovf  <= r_ovf | w_step[WIDTH];
      end else if (w_req) begin
        r_pre  <= r_pre + DIV_W'(1);
      end
    end
  end

  assign cnt  = r_cnt;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;
  assign eq   = (r_cnt == max_val);
  assign zero = (r_cnt == '0);

endmodule

// File: tb/tb_counter_ud.sv
// Directed bench for counter_ud: a wrap-mode and a saturate-mode instance share
// the same stimulus and are checked against hand-computed sequences.
module tb_counter_ud;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, inc, dec;
  logic [7:0] load_val, max_val;
  logic [3:0] div;

  logic [7:0] cnt0, cnt1;
  logic       eq0, zero0, wrap0, ovf0;
  logic       eq1, zero1, wrap1, ovf1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  counter_ud #(.WIDTH(8), .DIV_W(4), .SATURATE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .inc(inc), .dec(dec), .div(div), .max_val(max_val),
    .cnt(cnt0), .eq(eq0), .zero(zero0), .wrap(wrap0), .ovf(ovf0));

  counter_ud #(.WIDTH(8), .DIV_W(4), .SATURATE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .inc(inc), .dec(dec), .div(div), .max_val(max_val),
    .cnt(cnt1), .eq(eq1), .zero(zero1), .wrap(wrap1), .ovf(ovf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic c, input logic l, input logic i, input logic d);
    clr = c; load = l; inc = i; dec = d;
  endtask

  initial begin
    int w0_cnt[7]  = '{1, 2, 3, 4, 5, 0, 1};
    int w0_wrap[7] = '{0, 0, 0, 0, 0, 1, 0};
    int s0_cnt[7]  = '{1, 2, 3, 4, 5, 5, 5};
    int s0_wrap[7] = '{0, 0, 0, 0, 0, 1, 1};
    int d_cnt[9]   = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
    int su_cnt[6]  = '{1, 2, 3, 3, 3, 3};
    int su_wrap[6] = '{0, 0, 0, 1, 1, 1};
    int wu_cnt[6]  = '{1, 2, 3, 0, 1, 2};
    int wu_wrap[6] = '{0, 0, 0, 1, 0, 0};
    int sd_cnt[5]  = '{2, 1, 0, 0, 0};
    int sd_wrap[5] = '{0, 0, 0, 1, 1};
    int wd_cnt[5]  = '{1, 0, 3, 2, 1};
    int wd_wrap[5] = '{0, 0, 1, 0, 0};

    rst_n = 1'b0; set_in(0, 0, 0, 0);
    load_val = 8'd0; max_val = 8'd5; div = 4'd0;
    #12;
    chk("rst_cnt",  cnt0, 0);
    chk("rst_wrap", wrap0, 0);
    chk("rst_ovf",  ovf0, 0);
    chk("rst_zero", zero0, 1);
    chk("rst_eq",   eq0, 0);
    chk("rst_cnt_s", cnt1, 0);

    // Basic up count, div=0, max_val=5
    rst_n = 1'b1; inc = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("up_cnt%0d", k),    cnt0,  w0_cnt[k]);
      chk($sformatf("up_wrap%0d", k),   wrap0, w0_wrap[k]);
      chk($sformatf("up_ovf%0d", k),    ovf0,  (k >= 5) ? 1 : 0);
      chk($sformatf("up_eq%0d", k),     eq0,   (w0_cnt[k] == 5) ? 1 : 0);
      chk($sformatf("sup_cnt%0d", k),   cnt1,  s0_cnt[k]);
      chk($sformatf("sup_wrap%0d", k),  wrap1, s0_wrap[k]);
    end

    // Prescaler div=2
    set_in(1, 0, 0, 0);
    tick();
    chk("clr_cnt", cnt0, 0);
    chk("clr_ovf", ovf0, 0);
    div = 4'd2; set_in(0, 0, 1, 0);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("div_cnt%0d", k), cnt0, d_cnt[k]);
      chk($sformatf("div_wrap%0d", k), wrap0, 0);
    end
    tick();
    chk("div_pre1_cnt", cnt0, 3);
    div = 4'd0;
    tick();
    chk("div_lower_cnt", cnt0, 4);

    // Saturate vs wrap, max_val=3
    set_in(1, 0, 0, 0); max_val = 8'd3;
    tick();
    set_in(0, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("su_cnt%0d", k),  cnt1,  su_cnt[k]);
      chk($sformatf("su_wrap%0d", k), wrap1, su_wrap[k]);
      chk($sformatf("wu_cnt%0d", k),  cnt0,  wu_cnt[k]);
      chk($sformatf("wu_wrap%0d", k), wrap0, wu_wrap[k]);
    end
    set_in(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("sd_cnt%0d", k),  cnt1,  sd_cnt[k]);
      chk($sformatf("sd_wrap%0d", k), wrap1, sd_wrap[k]);
      chk($sformatf("wd_cnt%0d", k),  cnt0,  wd_cnt[k]);
      chk($sformatf("wd_wrap%0d", k), wrap0, wd_wrap[k]);
    end
    chk("sd_zero", zero1, 1);

    // Underflow at zero, and inc=dec=1 holding the prescaler
    set_in(1, 0, 0, 0); max_val = 8'd9; div = 4'd1;
    tick();
    set_in(0, 0, 0, 1);
    tick();
    chk("dn_pre_cnt",  cnt0, 0);
    chk("dn_pre_wrap", wrap0, 0);
    set_in(0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("both_cnt%0d", k), cnt0, 0);
    end
    set_in(0, 0, 0, 1);
    tick();
    chk("uf_cnt",    cnt0, 9);
    chk("uf_wrap",   wrap0, 1);
    chk("uf_eq",     eq0, 1);
    chk("uf_cnt_s",  cnt1, 0);
    chk("uf_wrap_s", wrap1, 1);
    set_in(0, 0, 1, 1);
    tick();
    chk("both_hold_cnt",  cnt0, 9);
    chk("both_hold_wrap", wrap0, 0);
    chk("ovf_sticky",     ovf0, 1);

    // Out-of-range load
    div = 4'd0; load_val = 8'd200; max_val = 8'd100;
    set_in(0, 1, 0, 0);
    tick();
    chk("ld_cnt",  cnt0, 200);
    chk("ld_wrap", wrap0, 0);
    chk("ld_ovf",  ovf0, 1);
    set_in(0, 0, 1, 0);
    tick();
    chk("oor_up_cnt",    cnt0, 0);
    chk("oor_up_wrap",   wrap0, 1);
    chk("oor_up_cnt_s",  cnt1, 100);
    chk("oor_up_wrap_s", wrap1, 1);
    set_in(0, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 1);
    tick();
    chk("oor_dn_cnt",   cnt0, 199);
    chk("oor_dn_cnt_s", cnt1, 199);
    chk("oor_dn_wrap",  wrap0, 0);
    load_val = 8'd100; set_in(0, 1, 1, 0);
    tick();
    chk("ld_tick_cnt",  cnt0, 100);
    chk("ld_tick_wrap", wrap0, 0);

    // clr beats a coincident tick
    set_in(1, 0, 1, 0);
    tick();
    chk("clr_tick_cnt",  cnt0, 0);
    chk("clr_tick_wrap", wrap0, 0);
    chk("clr_tick_ovf",  ovf0, 0);

    // Asynchronous reset mid-count, prescaler must restart
    max_val = 8'd2; set_in(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_cnt", cnt0, 1);
    chk("pre_rst_ovf", ovf0, 1);
    div = 4'd1;
    tick();
    chk("pre_rst_hold", cnt0, 1);
    inc = 1'b0; rst_n = 1'b0;
    #2;
    chk("arst_cnt",  cnt0, 0);
    chk("arst_ovf",  ovf0, 0);
    chk("arst_wrap", wrap0, 0);
    chk("arst_zero", zero0, 1);
    chk("arst_eq",   eq0, 0);
    rst_n = 1'b1; inc = 1'b1;
    tick();
    chk("arst_req1", cnt0, 0);
    tick();
    chk("arst_req2", cnt0, 1);

    // max_val=0: every tick is a limit event
    set_in(1, 0, 0, 0); div = 4'd0; max_val = 8'd0;
    tick();
    chk("m0_eq", eq0, 1);
    set_in(0, 0, 1, 0);
    tick();
    chk("m0_up_cnt",    cnt0, 0);
    chk("m0_up_wrap",   wrap0, 1);
    chk("m0_up_wrap_s", wrap1, 1);
    set_in(0, 0, 0, 1);
    tick();
    chk("m0_dn_cnt",  cnt0, 0);
    chk("m0_dn_wrap", wrap0, 1);
    set_in(0, 0, 0, 0);
    tick();
    chk("m0_idle_wrap", wrap0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
